nios_test_cpu_debug_mem_access: RTL and testbench
=================================================

# nios_test_cpu_debug_mem_access

Sysclk-domain debug memory sequencer that sits directly downstream of the CPU debug-slave JTAG bridge. It consumes the bridge's 38-bit `jdo` word and `take_action_ocimem_*` strobes and turns them into single-word read/write transactions on the OCI debug RAM port. It returns `MonDReg`, `monitor_ready` and `monitor_error` to the bridge for the next JTAG scan. Addresses auto-increment, so the host can stream consecutive words.

## Interface
Parameters:
- `ADDR_W`, 9: debug RAM word-address width (512 words).
- `TIMEOUT`, 255: maximum cycles a transaction may stay outstanding; range 2..255.

Ports:
- `clk` in 1: system clock; the only clock.
- `reset` in 1: synchronous, active-high reset.
- `jdo` in 38: command/data word from the JTAG bridge, valid in any cycle a strobe is high.
- `take_action_ocimem_a` in 1: load-address strobe, one cycle wide.
- `take_action_ocimem_b` in 1: write-data strobe, one cycle wide.
- `take_no_action_ocimem_a` in 1: read-next strobe, one cycle wide.
- `mem_address` out ADDR_W: debug RAM word address.
- `mem_writedata` out 32: write data.
- `mem_read` out 1: read request, held until accepted.
- `mem_write` out 1: write request, held until accepted.
- `mem_waitrequest` in 1: RAM stall; a request is accepted in a cycle where the request is high and this is low.
- `mem_readdata` in 32: read data, valid with `mem_readdatavalid`.
- `mem_readdatavalid` in 1: read data strobe.
- `MonDReg` out 32: monitor data register returned to the bridge.
- `monitor_ready` out 1: last command complete, `MonDReg` valid.
- `monitor_error` out 1: last command timed out or overran.

## Operation
- Registers:
  - address register `addr` (ADDR_W bits);
  - `MonDReg`;
  - a state machine with states IDLE, WR_REQ, RD_REQ, RD_WAIT;
  - an 8-bit timeout counter `tmo`.
- Commands are decoded only in IDLE. Priority is `take_action_ocimem_b` > `take_action_ocimem_a` > `take_no_action_ocimem_a`.
  - Write (`_b`): `MonDReg` <= `jdo[34:3]`, `mem_writedata` <= `jdo[34:3]`, go to WR_REQ.
  - Load address (`_a`): `addr` <= `jdo[ADDR_W+16:17]`. If `jdo[35]`=1, also go to RD_REQ (address-and-read). Otherwise the command completes immediately.
  - Read-next (`take_no_action_ocimem_a`): go to RD_REQ at the current `addr`.
- Any accepted command clears `monitor_ready` and `monitor_error` in the acceptance cycle. A load-only command sets `monitor_ready` back to 1 on the next cycle.
- WR_REQ: `mem_write`=1, `mem_address`=`addr`. On acceptance, `addr` <= `addr`+1, `monitor_ready`<=1, go to IDLE.
- RD_REQ: `mem_read`=1. On acceptance, go to RD_WAIT with `mem_read`=0.
- RD_WAIT: on `mem_readdatavalid`, `MonDReg` <= `mem_readdata`, `addr` <= `addr`+1, `monitor_ready`<=1, go to IDLE. A `mem_readdatavalid` in the same cycle as acceptance completes RD_WAIT immediately on the next edge.
- Address arithmetic is modulo 2^ADDR_W: 511+1 wraps to 0, with no error.
- Timeout:
  - `tmo` clears on entry to any non-IDLE state and increments each non-IDLE cycle.
  - When `tmo` reaches TIMEOUT: drop requests, go to IDLE, set `monitor_error`=1 and `monitor_ready`=1.
  - On timeout, `MonDReg` and `addr` are left unchanged.
- Overrun: any strobe arriving while not in IDLE is discarded and sets `monitor_error`=1 (sticky until the next accepted command). The in-flight transaction continues unaffected.
- A late `mem_readdatavalid` arriving in IDLE is ignored.

## Timing
- Reset values: `MonDReg`=0, `monitor_ready`=0, `monitor_error`=0, `mem_read`=0, `mem_write`=0, `mem_address`=0, `mem_writedata`=0, `addr`=0, state IDLE.
- Reset asserted mid-transaction drops the request on the next edge; no completion is reported.
- All outputs are registered. A strobe in cycle N drives `mem_read`/`mem_write` high in cycle N+1.
- Write with `mem_waitrequest` low: accepted in N+1, `monitor_ready`=1 in N+2. Each wait cycle adds one cycle.
- Read with zero wait and `mem_readdatavalid` in cycle N+2: `MonDReg` updated and `monitor_ready`=1 in N+3.
- `mem_address`, `mem_writedata` and the request are held stable while `mem_waitrequest`=1.
- Back-to-back commands: the earliest new command is accepted in the cycle `monitor_ready` rises.

## Test plan
- Reset, then load-address with `jdo[25:17]`=9'h010 and `jdo[35]`=0 → no bus activity; `monitor_ready`=1 two cycles after the strobe; `mem_address` is 0x010 on the next request.
- Write with `jdo[34:3]`=0xDEADBEEF and 3 wait cycles → `mem_write` held for 4 cycles at address 0x010; `monitor_ready`=1; next address is 0x011.
- Load-and-read at 0x1FF; RAM returns 0x12345678 two cycles after acceptance → `MonDReg`=0x12345678; address wraps to 0x000; a following read-next issues `mem_address`=0.
- Read with `mem_readdatavalid` never asserted → after 255 non-IDLE cycles: `mem_read`=0, `monitor_error`=1, `monitor_ready`=1; `MonDReg` and `addr` unchanged.
- Write strobe while RD_WAIT is pending → strobe ignored and `monitor_error`=1. The read still completes with correct `MonDReg`; the next accepted command clears the error.
- All three strobes in the same IDLE cycle → only the write executes.
- Reset asserted during WR_REQ → `mem_write`=0 on the next edge; all outputs are at reset values.

Source files
------------

// File: rtl/nios_test_cpu_debug_mem_access.sv
// Debug memory sequencer between the CPU debug-slave JTAG bridge and the OCI debug RAM.
// Turns ocimem strobes into single-word RAM accesses with address auto-increment and a timeout.
module nios_test_cpu_debug_mem_access #(
    parameter int ADDR_W  = 9,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_writedata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic              mem_waitrequest,
    input  logic [31:0]       mem_readdata,
    input  logic              mem_readdatavalid,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_REQ  = 2'd1,
        RD_REQ  = 2'd2,
        RD_WAIT = 2'd3
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t            state_r;
    state_t            state_s;
    logic [ADDR_W-1:0] addr_r;
    logic [7:0]        tmo_r;
    logic [31:0]       mon_r;
    logic [31:0]       wdata_r;
    logic              ready_r;
    logic              error_r;
    logic              rd_r;
    logic              wr_r;
    logic              load_pend_r;
    logic              cmd_wr_s;
    logic              cmd_ld_s;
    logic              cmd_rd_s;
    logic              accept_s;
    logic              done_s;
    logic              capture_s;
    logic              tmo_hit_s;
    logic              tmo_last_s;
    logic              overrun_s;
    logic              unused_jdo_s;

    // Bits of the bridge word this block never looks at
    assign unused_jdo_s = ^{jdo[37:36], jdo[2:0]};

    assign tmo_last_s = (tmo_r >= TMO_LAST);
    assign accept_s   = cmd_wr_s | cmd_ld_s | cmd_rd_s;
    assign overrun_s  = (state_r != IDLE) &&
                        (take_action_ocimem_a || take_action_ocimem_b || take_no_action_ocimem_a);

    // Command decode, bus handshake progress and timeout detection
    always_comb begin
        state_s   = state_r;
        cmd_wr_s  = 1'b0;
        cmd_ld_s  = 1'b0;
        cmd_rd_s  = 1'b0;
        done_s    = 1'b0;
        capture_s = 1'b0;
        tmo_hit_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (take_action_ocimem_b) begin
                    cmd_wr_s = 1'b1;
                    state_s  = WR_REQ;
                end else if (take_action_ocimem_a) begin
                    cmd_ld_s = 1'b1;
                    state_s  = jdo[35] ? RD_REQ : IDLE;
                end else if (take_no_action_ocimem_a) begin
                    cmd_rd_s = 1'b1;
                    state_s  = RD_REQ;
                end else begin
                    state_s = IDLE;
                end
            end
            WR_REQ: begin
                if (!mem_waitrequest) begin
                    done_s  = 1'b1;
                    state_s = IDLE;
                end else if (tmo_last_s) begin
                    tmo_hit_s = 1'b1;
                    state_s   = IDLE;
                end else begin
                    state_s = WR_REQ;
                end
            end
            RD_REQ: begin
                // Data returning in the acceptance cycle finishes the read outright
                if (!mem_waitrequest && mem_readdatavalid) begin
                    done_s    = 1'b1;
                    capture_s = 1'b1;
                    state_s   = IDLE;
                end else if (tmo_last_s) begin
                    tmo_hit_s = 1'b1;
                    state_s   = IDLE;
                end else if (!mem_waitrequest) begin
                    state_s = RD_WAIT;
                end else begin
                    state_s = RD_REQ;
                end
            end
            RD_WAIT: begin
                if (mem_readdatavalid) begin
                    done_s    = 1'b1;
                    capture_s = 1'b1;
                    state_s   = IDLE;
                end else if (tmo_last_s) begin
                    tmo_hit_s = 1'b1;
                    state_s   = IDLE;
                end else begin
                    state_s = RD_WAIT;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, address, data and monitor status registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            addr_r      <= '0;
            tmo_r       <= 8'd0;
            mon_r       <= 32'd0;
            wdata_r     <= 32'd0;
            ready_r     <= 1'b0;
            error_r     <= 1'b0;
            rd_r        <= 1'b0;
            wr_r        <= 1'b0;
            load_pend_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            rd_r        <= (state_s == RD_REQ);
            wr_r        <= (state_s == WR_REQ);
            load_pend_r <= cmd_ld_s && !jdo[35];
            tmo_r       <= (state_r == IDLE) ? 8'd0 : tmo_r + 8'd1;

            if (cmd_wr_s) begin
                mon_r   <= jdo[34:3];
                wdata_r <= jdo[34:3];
            end else if (capture_s) begin
                mon_r <= mem_readdata;
            end

            if (cmd_ld_s) begin
                addr_r <= jdo[ADDR_W+16:17];
            end else if (done_s) begin
                addr_r <= addr_r + ADDR_W'(1);
            end

            if (accept_s) begin
                ready_r <= 1'b0;
            end else if (load_pend_r || done_s || tmo_hit_s) begin
                ready_r <= 1'b1;
            end

            // Error stays set until the next accepted command
            if (accept_s) begin
                error_r <= 1'b0;
            end else if (tmo_hit_s || overrun_s) begin
                error_r <= 1'b1;
            end
        end
    end

    assign mem_address   = addr_r;
    assign mem_writedata = wdata_r;
    assign mem_read      = rd_r;
    assign mem_write     = wr_r;
    assign MonDReg       = mon_r;
    assign monitor_ready = ready_r;
    assign monitor_error = error_r;

endmodule

// File: tb/tb_nios_test_cpu_debug_mem_access.sv
// Scoreboard bench for the debug memory sequencer: randomized commands against a
// word-array reference model, with a behavioural RAM responding on the bus.
module tb_nios_test_cpu_debug_mem_access;

    localparam int TMO = 255;

    logic        clk;
    logic        reset;
    logic [37:0] jdo;
    logic        take_action_ocimem_a;
    logic        take_action_ocimem_b;
    logic        take_no_action_ocimem_a;
    logic [8:0]  mem_address;
    logic [31:0] mem_writedata;
    logic        mem_read;
    logic        mem_write;
    logic        mem_waitrequest;
    logic [31:0] mem_readdata;
    logic        mem_readdatavalid;
    logic [31:0] MonDReg;
    logic        monitor_ready;
    logic        monitor_error;

    nios_test_cpu_debug_mem_access #(.ADDR_W(9), .TIMEOUT(TMO)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .mem_address             (mem_address),
        .mem_writedata           (mem_writedata),
        .mem_read                (mem_read),
        .mem_write               (mem_write),
        .mem_waitrequest         (mem_waitrequest),
        .mem_readdata            (mem_readdata),
        .mem_readdatavalid       (mem_readdatavalid),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error)
    );

    typedef struct {
        logic [31:0] mon;
        logic        err;
        int          lat;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [9:0]  bus_q[$];
    logic [31:0] ram     [512];
    logic [31:0] ref_mem [512];
    logic [8:0]  maddr;
    logic [31:0] mon_m;
    int          checks;
    int          failures;
    int          cyc;
    int          cfg_wait;
    int          cfg_rd_lat;
    bit          cfg_rd_never;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Behavioural RAM: configurable wait states and read latency
    initial begin : ram_model
        int         wait_left;
        int         rd_cnt;
        bit         busy;
        logic [8:0] rd_addr;
        logic [8:0] hold_addr;
        logic [31:0] hold_wd;
        wait_left = 0;
        rd_cnt = 0;
        busy = 1'b0;
        rd_addr = 9'd0;
        hold_addr = 9'd0;
        hold_wd = 32'd0;
        mem_waitrequest = 1'b0;
        mem_readdatavalid = 1'b0;
        mem_readdata = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            mem_readdatavalid = 1'b0;
            if (reset === 1'b1) begin
                busy = 1'b0;
                rd_cnt = 0;
                mem_waitrequest = 1'b0;
            end else begin
                if (rd_cnt > 0) begin
                    rd_cnt--;
                    if (rd_cnt == 0) begin
                        mem_readdatavalid = 1'b1;
                        mem_readdata = ram[rd_addr];
                    end
                end
                if (mem_read === 1'b1 || mem_write === 1'b1) begin
                    if (!busy) begin
                        busy = 1'b1;
                        wait_left = cfg_wait;
                        hold_addr = mem_address;
                        hold_wd = mem_writedata;
                    end else begin
                        check("addr_stable", mem_address, hold_addr);
                        check("wdata_stable", mem_writedata, hold_wd);
                    end
                    if (wait_left > 0) begin
                        mem_waitrequest = 1'b1;
                        wait_left--;
                    end else begin
                        mem_waitrequest = 1'b0;
                        busy = 1'b0;
                        if (bus_q.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL unexpected_bus_request actual=%0h required=none", {mem_write, mem_address});
                        end else begin
                            check("bus_request", {mem_write, mem_address}, bus_q.pop_front());
                        end
                        if (mem_write === 1'b1) begin
                            ram[mem_address] = mem_writedata;
                        end else if (!cfg_rd_never) begin
                            rd_cnt = cfg_rd_lat;
                            rd_addr = mem_address;
                        end
                    end
                end else begin
                    busy = 1'b0;
                    mem_waitrequest = 1'b0;
                end
            end
        end
    end

    // Scoreboard monitor: every rising monitor_ready retires one command
    initial begin : monitor
        logic prev_ready;
        exp_t e;
        prev_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (monitor_ready === 1'b1 && prev_ready == 1'b0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_completion actual=ready required=no_command");
                end else begin
                    e = exp_q.pop_front();
                    check("mon_dreg", MonDReg, e.mon);
                    check("monitor_error", monitor_error, e.err);
                    check("latency", 64'(cyc - e.cyc), 64'(e.lat));
                end
            end
            prev_ready = (monitor_ready === 1'b1);
        end
    end

    // Reference model: what one command should do, from the command rules alone
    task automatic model_cmd(input bit w, input bit a, input bit na, input logic [37:0] j,
                             input int wt, input int rl, input bit never, input bit ovr);
        exp_t e;
        bit   rd;
        e.err = ovr;
        e.cyc = cyc;
        e.lat = 2;
        if (w) begin
            ref_mem[maddr] = j[34:3];
            mon_m = j[34:3];
            bus_q.push_back({1'b1, maddr});
            maddr = maddr + 9'd1;
            e.lat = 2 + wt;
        end else begin
            rd = na;
            if (a) begin
                maddr = j[25:17];
                rd = j[35];
            end
            if (rd) begin
                bus_q.push_back({1'b0, maddr});
                if (never) begin
                    e.lat = TMO + 1;
                    e.err = 1'b1;
                end else begin
                    mon_m = ref_mem[maddr];
                    maddr = maddr + 9'd1;
                    e.lat = 2 + wt + rl;
                end
            end
        end
        e.mon = mon_m;
        exp_q.push_back(e);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (monitor_ready !== 1'b1 && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (monitor_ready !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL ready_wait actual=%b required=1 after %0d cycles", monitor_ready, n);
        end
    endtask

    // Issue one command (caller sits just after a rising edge); intr>0 adds a write strobe intr cycles later
    task automatic run_cmd(input bit w, input bit a, input bit na, input logic [37:0] j,
                           input int wt, input int rl, input bit never, input int intr);
        cfg_wait = wt;
        cfg_rd_lat = rl;
        cfg_rd_never = never;
        model_cmd(w, a, na, j, wt, rl, never, intr > 0);
        jdo = j;
        take_action_ocimem_b = w;
        take_action_ocimem_a = a;
        take_no_action_ocimem_a = na;
        @(posedge clk);
        #1;
        take_action_ocimem_b = 1'b0;
        take_action_ocimem_a = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        jdo = 38'({$urandom, $urandom});
        if (intr > 0) begin
            repeat (intr - 1) begin
                @(posedge clk);
                #1;
            end
            take_action_ocimem_b = 1'b1;
            @(posedge clk);
            #1;
            take_action_ocimem_b = 1'b0;
        end
        wait_ready();
        cfg_rd_never = 1'b0;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [37:0] j;
        logic [2:0]  f;
        checks = 0;
        failures = 0;
        maddr = 9'd0;
        mon_m = 32'd0;
        cfg_wait = 0;
        cfg_rd_lat = 1;
        cfg_rd_never = 1'b0;
        for (int i = 0; i < 512; i++) begin
            ram[i] = $urandom;
            ref_mem[i] = ram[i];
        end
        reset = 1'b1;
        jdo = 38'd0;
        take_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_mondreg", MonDReg, 32'd0);
        check("reset_ready", monitor_ready, 1'b0);
        check("reset_error", monitor_error, 1'b0);
        check("reset_rd_wr", {mem_read, mem_write}, 2'b00);
        check("reset_address", mem_address, 9'd0);

        // Load address 0x010, no read
        j = 38'd0;
        j[25:17] = 9'h010;
        run_cmd(1'b0, 1'b1, 1'b0, j, 0, 1, 1'b0, 0);
        // Write DEADBEEF with three wait states
        j = 38'd0;
        j[34:3] = 32'hDEADBEEF;
        run_cmd(1'b1, 1'b0, 1'b0, j, 3, 1, 1'b0, 0);
        // Load-and-read at the top word; data two cycles after acceptance
        ram[511] = 32'h12345678;
        ref_mem[511] = 32'h12345678;
        j = 38'd0;
        j[25:17] = 9'h1FF;
        j[35] = 1'b1;
        run_cmd(1'b0, 1'b1, 1'b0, j, 0, 2, 1'b0, 0);
        // Read-next after wrap
        run_cmd(1'b0, 1'b0, 1'b1, 38'd0, 1, 1, 1'b0, 0);
        // Read data never returned
        run_cmd(1'b0, 1'b0, 1'b1, 38'd0, 0, 1, 1'b1, 0);
        // Write strobe during an outstanding read
        run_cmd(1'b0, 1'b0, 1'b1, 38'd0, 0, 4, 1'b0, 3);
        // Next accepted command clears the error
        j = 38'd0;
        j[25:17] = 9'h0A5;
        run_cmd(1'b0, 1'b1, 1'b0, j, 0, 1, 1'b0, 0);
        // All three strobes together
        j = 38'({$urandom, $urandom});
        j[35] = 1'b1;
        run_cmd(1'b1, 1'b1, 1'b1, j, 2, 1, 1'b0, 0);

        for (int i = 0; i < 40; i++) begin
            f = 3'($urandom_range(1, 7));
            j = 38'({$urandom, $urandom});
            run_cmd(f[0], f[1], f[2], j, $urandom_range(0, 3), $urandom_range(1, 3), 1'b0, 0);
        end

        // Reset in the middle of a stalled write
        cfg_wait = 10;
        jdo = 38'({$urandom, $urandom});
        take_action_ocimem_b = 1'b1;
        @(posedge clk);
        #1;
        take_action_ocimem_b = 1'b0;
        check("write_pending", mem_write, 1'b1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_write", mem_write, 1'b0);
        check("rst_mid_read", mem_read, 1'b0);
        check("rst_mid_mondreg", MonDReg, 32'd0);
        check("rst_mid_status", {monitor_ready, monitor_error}, 2'b00);
        check("rst_mid_address", mem_address, 9'd0);
        check("rst_mid_wdata", mem_writedata, 32'd0);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_no_completion", monitor_ready, 1'b0);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        check("bus_queue_empty", 64'(bus_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
